// File: rtl/byte_packer_pkg.sv
// Shared constants and types for the byte packer.
// The BYTE_PACKER_LAST_EN macro widens fifo_entry_t with keep/last sideband.
package byte_packer_pkg;

  localparam int BP_DATA_WIDTH = 8;
  localparam int BP_LANES      = 4;
  localparam int BP_FIFO_DEPTH = 4;

  localparam int LANE_IDX_W = $clog2(BP_LANES);
  localparam int FILL_W     = $clog2(BP_FIFO_DEPTH) + 1;

  typedef logic [BP_DATA_WIDTH*BP_LANES-1:0] word_t;
  typedef logic [BP_LANES-1:0]               keep_t;

`ifdef BYTE_PACKER_LAST_EN
  typedef struct packed {
    logic  last;
    keep_t keep;
    word_t word;
  } fifo_entry_t;
`else
  typedef struct packed {
    word_t word;
  } fifo_entry_t;
`endif

  // Keep mask with bits 0..idx set (lanes filled so far, including idx).
  function automatic keep_t keep_upto(input logic [LANE_IDX_W-1:0] idx);
    keep_t k;
    for (int i = 0; i < BP_LANES; i++) begin
      k[i] = (LANE_IDX_W'(i) <= idx);
    end
    return k;
  endfunction

endpackage

// File: rtl/byte_packer_fifo.sv
// Synchronous FIFO with registered full/empty/fill flags; push while full is
// accepted only when a pop frees the slot in the same cycle.
module byte_packer_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] fill
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] last_ptr_s;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_en_s, rd_en_s;

  always_comb begin
    rd_en_s  = pop && !empty_q;
    wr_en_s  = push && (!full_q || rd_en_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
    full_d  = (fill_d == CNT_W'(DEPTH));
    empty_d = (fill_d == CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // While empty the head shows the most recently written slot.
  assign last_ptr_s = wr_ptr_q - PTR_W'(1);
  assign rdata      = empty_q ? mem_q[last_ptr_s] : mem_q[rd_ptr_q];
  assign full       = full_q;
  assign empty      = empty_q;
  assign fill       = fill_q;

endmodule

// File: rtl/byte_packer.sv
// Packs a non-stallable byte stream into little-endian words behind a FIFO,
// with sticky overflow. BYTE_PACKER_LAST_EN adds din_last/dout_last/dout_keep.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int DATA_WIDTH = BP_DATA_WIDTH,
  parameter int LANES      = BP_LANES,
  parameter int FIFO_DEPTH = BP_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_vld,
`ifdef BYTE_PACKER_LAST_EN
  input  logic                          din_last,
  output logic                          dout_last,
  output logic [LANES-1:0]              dout_keep,
`endif
  output logic [DATA_WIDTH*LANES-1:0]   dout,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int WORD_W = DATA_WIDTH * LANES;
  localparam int IDX_W  = $clog2(LANES);
`ifdef BYTE_PACKER_LAST_EN
  localparam int ENTRY_W = WORD_W + LANES + 1;
`else
  localparam int ENTRY_W = WORD_W;
`endif

  logic [IDX_W-1:0]   lc_q, lc_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [WORD_W-1:0]  word_s;
  logic               done_s;
  logic               pop_s;
  logic               full_s, empty_s;
  logic [ENTRY_W-1:0] push_entry_s, head_entry_s;
`ifdef BYTE_PACKER_LAST_EN
  logic [LANES-1:0]   keep_s;
`endif

  // Accumulator with the incoming byte merged into lane lc.
  always_comb begin
    word_s = acc_q;
    for (int k = 0; k < LANES; k++) begin
      if (lc_q == IDX_W'(k)) begin
        word_s[k*DATA_WIDTH +: DATA_WIDTH] = din;
      end else begin
        word_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef BYTE_PACKER_LAST_EN
    for (int k = 0; k < LANES; k++) begin
      keep_s[k] = (IDX_W'(k) <= lc_q);
    end
`endif
  end

  always_comb begin
    done_s = 1'b0;
    if (din_vld) begin
`ifdef BYTE_PACKER_LAST_EN
      done_s = (lc_q == IDX_W'(LANES - 1)) || din_last;
`else
      done_s = (lc_q == IDX_W'(LANES - 1));
`endif
    end else begin
      done_s = 1'b0;
    end
  end

  assign pop_s = !empty_s && dout_rdy;

  // Completion clears the accumulator so a short word carries zeroed upper lanes.
  always_comb begin
    lc_d  = lc_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (din_vld) begin
      if (done_s) begin
        lc_d  = '0;
        acc_d = '0;
      end else begin
        lc_d  = lc_q + IDX_W'(1);
        acc_d = word_s;
      end
    end else begin
      lc_d  = lc_q;
      acc_d = acc_q;
    end
    if (done_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lc_q  <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      lc_q  <= lc_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef BYTE_PACKER_LAST_EN
  assign push_entry_s = {din_last, keep_s, word_s};
  assign dout_keep    = head_entry_s[WORD_W +: LANES];
  assign dout_last    = head_entry_s[ENTRY_W-1];
`else
  assign push_entry_s = word_s;
`endif

  byte_packer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (done_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (head_entry_s),
    .full  (full_s),
    .empty (empty_s),
    .fill  (fill)
  );

  assign dout     = head_entry_s[WORD_W-1:0];
  assign dout_vld = !empty_s;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: vector table plus directed sequences,
// with an occupancy model feeding a queue of expected words.
module tb_byte_packer;
  import byte_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_vld;
  logic        din_last;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic        ovf;
  logic [2:0]  fill;
`ifdef BYTE_PACKER_LAST_EN
  logic        dout_last;
  logic [3:0]  dout_keep;
`endif

  always #5 clk = ~clk;

  byte_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
`ifdef BYTE_PACKER_LAST_EN
    .din_last  (din_last),
    .dout_last (dout_last),
    .dout_keep (dout_keep),
`endif
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .ovf       (ovf),
    .fill      (fill)
  );

  typedef struct packed {
    word_t w;
    keep_t k;
    logic  l;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0] b;
    logic [7:0]      gap;
    word_t           exp;
  } vec_t;

  vec_t vecs [5];
  exp_t pend_q [$];
  exp_t exp_q [$];
  exp_t pe, me;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mlc, mfill;
  logic movf, pop_m, push_m, acc_m;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [7:0] b, input logic l);
    din      = b;
    din_vld  = 1'b1;
    din_last = l;
    tick();
    din_vld  = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic expect_word(input word_t w, input keep_t k, input logic l);
    pend_q.push_back({w, k, l});
  endtask

  function automatic word_t w4(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {a3, a2, a1, a};
  endfunction

  task automatic reset_check();
    chk("rst_dout_vld", 64'(dout_vld), 64'(0));
    chk("rst_fill", 64'(fill), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    din_vld = 1'b0;
    tick();
    reset_check();
    rst_n = 1'b1;
  endtask

  // Occupancy model: decides acceptance/drop of each completed word.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mlc   = 0;
        mfill = 0;
        movf  = 1'b0;
      end else begin
        pop_m  = (mfill != 0) && dout_rdy;
        push_m = 1'b0;
        acc_m  = 1'b0;
        if (din_vld) begin
          if (mlc == 3 || din_last) begin
            push_m = 1'b1;
            mlc    = 0;
          end else begin
            mlc = mlc + 1;
          end
        end
        if (push_m) begin
          if (pend_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending: word completed, got none queued, expected one");
          end else begin
            pe = pend_q.pop_front();
            if (mfill < 4 || pop_m) begin
              exp_q.push_back(pe);
              acc_m = 1'b1;
            end else begin
              movf = 1'b1;
            end
          end
        end
        mfill = mfill + (acc_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("dout_vld", 64'(dout_vld), 64'(mfill != 0));
        chk("fill", 64'(fill), 64'(mfill));
        chk("ovf", 64'(ovf), 64'(movf));
        if (dout_vld) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_word: got dout=%h, expected no word", dout);
          end else begin
            me = exp_q[0];
            chk("dout", 64'(dout), 64'(me.w));
`ifdef BYTE_PACKER_LAST_EN
            chk("dout_keep", 64'(dout_keep), 64'(me.k));
            chk("dout_last", 64'(dout_last), 64'(me.l));
`endif
            if (dout_rdy) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{b: {8'h44, 8'h33, 8'h22, 8'h11}, gap: 8'd0, exp: 32'h44332211};
    vecs[1] = '{b: {8'h04, 8'h03, 8'h02, 8'h01}, gap: 8'd3, exp: 32'h04030201};
    vecs[2] = '{b: {8'h08, 8'h07, 8'h06, 8'h05}, gap: 8'd3, exp: 32'h08070605};
    vecs[3] = '{b: {8'hEF, 8'hBE, 8'hAD, 8'hDE}, gap: 8'd1, exp: 32'hEFBEADDE};
    vecs[4] = '{b: {8'h00, 8'hFF, 8'h00, 8'hFF}, gap: 8'd0, exp: 32'h00FF00FF};

    rst_n    = 1'b0;
    din      = 8'h00;
    din_vld  = 1'b0;
    din_last = 1'b0;
    dout_rdy = 1'b1;
    idle(2);
    reset_check();
    mon_en = 1'b1;
    rst_n  = 1'b1;
    tick();

    // Table: packing order and din_vld gaps, sink always ready.
    for (int i = 0; i < 5; i++) begin
      expect_word(vecs[i].exp, 4'hF, 1'b0);
      for (int j = 0; j < 4; j++) begin
        drive(vecs[i].b[j], 1'b0);
        idle(int'(vecs[i].gap));
      end
    end
    idle(3);
    chk("table_drained", 64'(exp_q.size()), 64'(0));

    // Overflow: sink stalled, 5 words arrive, the 5th is dropped.
    dout_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) expect_word(w4(8'(i)), 4'hF, 1'b0);
      drive(8'(i), 1'b0);
      if (i == 15) begin
        chk("ovf_before_5th", 64'(ovf), 64'(0));
        chk("fill_full", 64'(fill), 64'(4));
      end
    end
    chk("ovf_after_5th", 64'(ovf), 64'(1));
    chk("fill_after_drop", 64'(fill), 64'(4));
    dout_rdy = 1'b1;
    idle(6);
    chk("ovf_drain_words", 64'(exp_q.size()), 64'(0));
    chk("ovf_sticky", 64'(ovf), 64'(1));
    do_reset();
    tick();

    // Full FIFO, pop coincides with the push of the next word.
    dout_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) expect_word(w4(8'(8'h20 + i)), 4'hF, 1'b0);
      if (i == 19) dout_rdy = 1'b1;
      drive(8'(8'h20 + i), 1'b0);
    end
    dout_rdy = 1'b0;
    chk("simul_fill", 64'(fill), 64'(4));
    chk("simul_ovf", 64'(ovf), 64'(0));
    dout_rdy = 1'b1;
    idle(6);
    chk("simul_drained", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a word discards the partial bytes.
    drive(8'hAA, 1'b0);
    drive(8'hBB, 1'b0);
    do_reset();
    expect_word(32'h04030201, 4'hF, 1'b0);
    for (int i = 1; i <= 4; i++) drive(8'(i), 1'b0);
    idle(3);
    chk("rst_mid_drained", 64'(exp_q.size()), 64'(0));

`ifdef BYTE_PACKER_LAST_EN
    // Early termination: short word zero-padded, then realigned to lane 0.
    expect_word(32'h00302010, 4'b0111, 1'b1);
    drive(8'h10, 1'b0);
    drive(8'h20, 1'b0);
    drive(8'h30, 1'b1);
    expect_word(32'h44434241, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'(8'h41 + i), 1'b0);
    idle(3);
    chk("last_drained", 64'(exp_q.size()), 64'(0));
`endif

    chk("pending_empty", 64'(pend_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Downstream consumer of the two-stage register delay chain.
- Takes the non-stallable 8-bit stream leaving the chain, plus a valid bit delayed alongside it, and packs groups of 4 bytes into 32-bit words.
- Words are buffered in a small FIFO and presented on a valid/ready interface to the next stage.
- Detects and flags overflow, because the source cannot be back-pressured.

Parameters:
- DATA_WIDTH, 8, width of one input byte lane.
- LANES, 4, input beats per output word; power of two, at least 2.
- FIFO_DEPTH, 4, output word buffer depth; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- din  in  DATA_WIDTH  input byte from the delay chain output.
- din_vld  in  1  din is valid this cycle; no ready exists (source cannot stall).
- dout  out  DATA_WIDTH*LANES  packed word at the FIFO head.
- dout_vld  out  1  FIFO not empty.
- dout_rdy  in  1  sink accepts dout this cycle.
- ovf  out  1  sticky: a completed word was dropped.
- fill  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state changes only on the rising edge of clk, including reset.
- Reset values while rst_n=0 at an edge:
  - dout_vld=0, dout=0, ovf=0, fill=0.
  - Lane counter=0; accumulator cleared.
  - FIFO pointers=0.
  - A partial word is discarded, and FIFO contents are discarded.
- Packing order is little-endian: the first byte of a group goes to dout[7:0], the LANES-th byte to the top lane.
- Lane counter lc, range 0..LANES-1:
  - Advances on each din_vld and wraps LANES-1 -> 0.
  - The lane lc of the accumulator is written with din.
- Word completion: on the cycle din_vld=1 and lc=LANES-1, the push word is {din, acc lanes LANES-2..0}. It is written directly to the FIFO; no extra accumulator cycle.
- Latency: a completed word appears on dout with dout_vld=1 one cycle after the cycle of its last byte, provided the FIFO was empty.
- Pop: when dout_vld && dout_rdy, the head advances. dout is stable while dout_vld=1 and dout_rdy=0.
- Push and pop in the same cycle:
  - Always permitted, including when the FIFO is full (the pop frees the slot).
  - fill is unchanged.
- Overflow: push with fill=FIFO_DEPTH and no pop in the same cycle:
  - The word is dropped.
  - ovf is set and held until reset.
  - The lane counter still wraps to 0, so packing stays aligned.
- Empty FIFO: dout_rdy is ignored and dout_vld=0. dout shows the last-written slot's value; it is not required to be 0 after the first write.
- Gaps: din_vld=0 cycles hold lc and acc indefinitely.
- Pointers wrap modulo FIFO_DEPTH. fill uses one extra bit to distinguish full from empty.

Optional Feature:
- Macro: BYTE_PACKER_LAST_EN.
- Defined:
  - Adds ports din_last (in, 1), dout_last (out, 1) and dout_keep (out, LANES).
  - din_vld && din_last forces a push of the current partial word.
  - Unfilled lanes are zero. keep bit k=1 for each filled lane, contiguous from bit 0.
  - dout_last=1 on that word; lc returns to 0.
  - Full words have keep all ones; dout_last = din_last of their final byte.
  - The FIFO stores word, keep and last together.
- Not defined: none of these ports exist; every word is complete and keep is implicitly all ones.

Decomposition:
- Package byte_packer_pkg holds:
  - LANE_IDX_W = clog2(LANES) and FILL_W.
  - Typedefs: word_t (DATA_WIDTH*LANES), keep_t (LANES), fifo_entry_t (word plus optional keep/last).
- Sub-module byte_packer_fifo: a synchronous FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/fill. It contains no packing logic.
- Top module: lane counter, accumulator, push/overflow logic.

Test Plan:
- Reset then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with dout_rdy=1 -> next cycle dout=0x44332211 and dout_vld=1 for exactly 1 cycle; ovf=0.
- Bytes 0x01..0x08 with din_vld gaps of 3 cycles between each -> dout sequence 0x04030201, 0x08070605; no extra words.
- dout_rdy=0, 20 bytes 0x00..0x13 -> fill reaches 4, ovf=1 after 5th word. Releasing dout_rdy drains exactly 4 words: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- FIFO full, then dout_rdy=1 on the same cycle the 4th byte of the next word arrives -> no drop, ovf stays 0, fill stays 4.
- 2 bytes 0xAA,0xBB, then rst_n=0 for 1 cycle, then 0x01..0x04 -> dout=0x04030201. The partial word is gone and dout_vld=0 during reset.
- BYTE_PACKER_LAST_EN: bytes 0x10,0x20,0x30 with din_last on 0x30 -> dout=0x00302010, dout_keep=0b0111, dout_last=1. The next 4 bytes pack from lane 0.
